// File: rtl/riscv_ctrl_pkg.sv
// Shared types and helpers for the multi-cycle core control path.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'd0,
    CAUSE_ILLEGAL     = 2'd1,
    CAUSE_MEM_TIMEOUT = 2'd2
  } trap_cause_t;

  localparam int NUM_CLASSES = 9;

  // True when exactly one decoder class flag is set.
  function automatic logic is_one_hot(input logic [NUM_CLASSES-1:0] flags);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      cnt = cnt + {3'b000, flags[k]};
    end
    return (cnt == 4'd1);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles of the current request and flags a timeout
// in the cycle where the count would reach MEM_TIMEOUT (0 disables it).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LAST_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);
  localparam logic TIMER_ON = (MEM_TIMEOUT > 0);

  logic [CNT_W-1:0] count_r;

  // Wait counter: cleared whenever no request is pending or one completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && TIMER_ON && (count_r != LAST)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // The wait cycle that would bring the count to MEM_TIMEOUT is the timeout.
  assign timeout = TIMER_ON && enable && (count_r == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle core control FSM: fetch/decode/execute/mem/writeback with
// memory handshake, illegal-class and memory-timeout traps, and instret.
module multicycle_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic                 r,
  input  logic                 i,
  input  logic                 i_load,
  input  logic                 i_jalr,
  input  logic                 s,
  input  logic                 sb,
  input  logic                 u_auipc,
  input  logic                 u_lui,
  input  logic                 uj_jal,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_addr_sel,
  output logic                 mem_we,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 pc_write,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  seq_state_t             state_r, state_nxt_s, boundary_s;
  trap_cause_t            cause_r, cause_nxt_s;
  logic [INSTRET_W-1:0]   instret_r;
  logic [NUM_CLASSES-1:0] flags_s;
  logic                   timeout_s;
  logic                   mem_req_s, mem_addr_sel_s, mem_we_s;
  logic                   ir_write_s, reg_write_s, pc_write_s;

  assign flags_s    = {r, i, i_load, i_jalr, s, sb, u_auipc, u_lui, uj_jal};
  assign boundary_s = halt ? ST_IDLE : ST_FETCH;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (~mem_req_s | mem_ready),
    .enable  (mem_req_s & ~mem_ready),
    .timeout (timeout_s)
  );

  // Next-state and strobe decode; strobes depend on the registered state,
  // with only ir_write and the MEM-state pc_write qualified by mem_ready.
  always_comb begin
    state_nxt_s    = state_r;
    cause_nxt_s    = cause_r;
    mem_req_s      = 1'b0;
    mem_addr_sel_s = 1'b0;
    mem_we_s       = 1'b0;
    ir_write_s     = 1'b0;
    reg_write_s    = 1'b0;
    pc_write_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!halt) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_write_s  = 1'b1;
          state_nxt_s = ST_DECODE;
        end else if (timeout_s) begin
          state_nxt_s = ST_TRAP;
          cause_nxt_s = CAUSE_MEM_TIMEOUT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_one_hot(flags_s)) begin
          state_nxt_s = ST_EXECUTE;
        end else begin
          state_nxt_s = ST_TRAP;
          cause_nxt_s = CAUSE_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        if (i_load || s) begin
          state_nxt_s = ST_MEM;
        end else if (sb) begin
          pc_write_s  = 1'b1;
          state_nxt_s = boundary_s;
        end else begin
          state_nxt_s = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        mem_req_s      = 1'b1;
        mem_addr_sel_s = 1'b1;
        mem_we_s       = s;
        if (mem_ready) begin
          if (s) begin
            pc_write_s  = 1'b1;
            state_nxt_s = boundary_s;
          end else begin
            state_nxt_s = ST_WRITEBACK;
          end
        end else if (timeout_s) begin
          state_nxt_s = ST_TRAP;
          cause_nxt_s = CAUSE_MEM_TIMEOUT;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WRITEBACK: begin
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        state_nxt_s = boundary_s;
      end
      ST_TRAP: begin
        state_nxt_s = ST_TRAP;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, trap cause and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cause_r   <= CAUSE_NONE;
      instret_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cause_r <= cause_nxt_s;
      if (pc_write_s) begin
        instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign mem_req      = mem_req_s;
  assign mem_addr_sel = mem_addr_sel_s;
  assign mem_we       = mem_we_s;
  assign ir_write     = ir_write_s;
  assign reg_write    = reg_write_s;
  assign pc_write     = pc_write_s;
  assign state        = state_r;
  assign trap         = (state_r == ST_TRAP);
  assign trap_cause   = cause_r;
  assign instret      = instret_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (MEM_TIMEOUT = 4, INSTRET_W = 4).
module tb_multicycle_sequencer;
  import riscv_ctrl_pkg::*;

  localparam logic [8:0] F_NONE = 9'b000000000;
  localparam logic [8:0] F_R    = 9'b100000000;
  localparam logic [8:0] F_I    = 9'b010000000;
  localparam logic [8:0] F_LOAD = 9'b001000000;
  localparam logic [8:0] F_S    = 9'b000010000;
  localparam logic [8:0] F_SB   = 9'b000001000;

  logic       clk = 1'b0;
  logic       reset, halt, mem_ready;
  logic [8:0] flags;
  logic       mem_req, mem_addr_sel, mem_we, ir_write, reg_write, pc_write;
  logic [2:0] state;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] instret;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_sequencer #(
    .MEM_TIMEOUT (4),
    .INSTRET_W   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .halt         (halt),
    .r            (flags[8]),
    .i            (flags[7]),
    .i_load       (flags[6]),
    .i_jalr       (flags[5]),
    .s            (flags[4]),
    .sb           (flags[3]),
    .u_auipc      (flags[2]),
    .u_lui        (flags[1]),
    .uj_jal       (flags[0]),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_addr_sel (mem_addr_sel),
    .mem_we       (mem_we),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .pc_write     (pc_write),
    .state        (state),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every strobe plus state in one call.
  task automatic chk_all(input string tag, input logic [2:0] st, input logic [5:0] strobes);
    chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
    chk({tag, ".strobes"}, {26'd0, mem_req, mem_addr_sel, mem_we, ir_write, reg_write, pc_write},
        {26'd0, strobes});
  endtask

  initial begin
    reset = 1'b1; halt = 1'b1; mem_ready = 1'b0; flags = F_NONE;
    tick(); tick();
    settle();
    chk_all("reset", 3'd0, 6'b000000);
    chk("reset.trap", {31'd0, trap}, 32'd0);
    chk("reset.cause", {30'd0, trap_cause}, 32'd0);
    chk("reset.instret", {28'd0, instret}, 32'd0);

    // R-type, zero-wait memory: F D E WB, retire in cycle 4.
    reset = 1'b0; halt = 1'b0; flags = F_R; mem_ready = 1'b1;
    tick(); settle(); chk_all("r.c1", 3'd1, 6'b100100);
    tick(); settle(); chk_all("r.c2", 3'd2, 6'b000000);
    tick(); settle(); chk_all("r.c3", 3'd3, 6'b000000);
    tick(); settle(); chk_all("r.c4", 3'd5, 6'b000011);
    tick(); flags = F_LOAD; settle();
    chk("r.instret", {28'd0, instret}, 32'd1);

    // Load with 3 wait cycles in MEM: retire in cycle 8.
    chk_all("ld.c1", 3'd1, 6'b100100);
    tick(); settle(); chk_all("ld.c2", 3'd2, 6'b000000);
    tick(); mem_ready = 1'b0; settle(); chk_all("ld.c3", 3'd3, 6'b000000);
    tick(); settle(); chk_all("ld.c4", 3'd4, 6'b110000);
    tick(); settle(); chk_all("ld.c5", 3'd4, 6'b110000);
    tick(); settle(); chk_all("ld.c6", 3'd4, 6'b110000);
    tick(); mem_ready = 1'b1; settle(); chk_all("ld.c7", 3'd4, 6'b110000);
    tick(); flags = F_S; settle(); chk_all("ld.c8", 3'd5, 6'b000011);
    tick(); settle();
    chk("ld.instret", {28'd0, instret}, 32'd2);

    // Store then branch back-to-back, zero-wait.
    chk_all("st.c1", 3'd1, 6'b100100);
    tick(); settle(); chk_all("st.c2", 3'd2, 6'b000000);
    tick(); settle(); chk_all("st.c3", 3'd3, 6'b000000);
    tick(); settle(); chk_all("st.c4", 3'd4, 6'b111001);
    tick(); flags = F_SB; settle(); chk_all("br.c1", 3'd1, 6'b100100);
    chk("st.instret", {28'd0, instret}, 32'd3);
    tick(); settle(); chk_all("br.c2", 3'd2, 6'b000000);
    tick(); settle(); chk_all("br.c3", 3'd3, 6'b000001);
    tick(); flags = F_I; settle();
    chk("br.instret", {28'd0, instret}, 32'd4);

    // I-type with halt raised in EXECUTE: retires, then IDLE until halt drops.
    chk_all("hi.c1", 3'd1, 6'b100100);
    tick(); settle(); chk_all("hi.c2", 3'd2, 6'b000000);
    tick(); halt = 1'b1; settle(); chk_all("hi.c3", 3'd3, 6'b000000);
    tick(); settle(); chk_all("hi.c4", 3'd5, 6'b000011);
    tick(); settle(); chk_all("hi.idle", 3'd0, 6'b000000);
    chk("hi.instret", {28'd0, instret}, 32'd5);
    tick(); halt = 1'b0; settle(); chk_all("hi.hold", 3'd0, 6'b000000);
    tick(); flags = F_S; settle(); chk_all("hi.resume", 3'd1, 6'b100100);

    // Reset asserted mid-MEM of a store.
    tick(); settle(); chk_all("rm.c2", 3'd2, 6'b000000);
    tick(); mem_ready = 1'b0; settle(); chk_all("rm.c3", 3'd3, 6'b000000);
    tick(); settle(); chk_all("rm.c4", 3'd4, 6'b111000);
    reset = 1'b1;
    tick(); settle(); chk_all("rm.after", 3'd0, 6'b000000);
    chk("rm.instret", {28'd0, instret}, 32'd0);

    // Fetch timeout after 4 wait cycles.
    reset = 1'b0; flags = F_R; mem_ready = 1'b0;
    tick(); settle(); chk_all("to.c1", 3'd1, 6'b100000);
    tick(); tick(); tick(); settle(); chk_all("to.c4", 3'd1, 6'b100000);
    tick(); mem_ready = 1'b1; settle(); chk_all("to.trap", 3'd6, 6'b000000);
    chk("to.flag", {31'd0, trap}, 32'd1);
    chk("to.cause", {30'd0, trap_cause}, 32'd2);
    tick(); settle(); chk_all("to.sticky", 3'd6, 6'b000000);
    chk("to.cause_held", {30'd0, trap_cause}, 32'd2);

    // mem_ready in the 4th wait cycle completes normally.
    reset = 1'b1; tick();
    reset = 1'b0; mem_ready = 1'b0; flags = F_R | F_S;
    settle(); chk("to2.cleared", {29'd0, trap, trap_cause}, 32'd0);
    tick(); tick(); tick(); tick(); mem_ready = 1'b1; settle();
    chk_all("to2.c4", 3'd1, 6'b100100);
    tick(); settle(); chk_all("to2.dec", 3'd2, 6'b000000);
    chk("to2.notrap", {31'd0, trap}, 32'd0);

    // r and s set together: illegal trap, sticky until reset.
    tick(); settle(); chk_all("il.trap", 3'd6, 6'b000000);
    chk("il.cause", {30'd0, trap_cause}, 32'd1);
    tick(); tick(); settle(); chk_all("il.sticky", 3'd6, 6'b000000);
    chk("il.flag", {31'd0, trap}, 32'd1);
    reset = 1'b1;
    tick(); settle(); chk_all("il.reset", 3'd0, 6'b000000);
    chk("il.cleared", {29'd0, trap, trap_cause}, 32'd0);

    // instret wraps modulo 2^4 over 16 back-to-back branches.
    reset = 1'b0; flags = F_SB; mem_ready = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) begin
      tick(); tick(); tick();
    end
    settle(); chk("wrap.15", {28'd0, instret}, 32'd15);
    tick(); tick(); tick(); settle();
    chk("wrap.0", {28'd0, instret}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Control FSM for the multi-cycle core variant: one shared memory port, one ALU/register-file datapath reused across cycles. It consumes the one-hot instruction-class flags produced by the existing instruction decoder and steps each instruction through fetch, decode, execute, memory and writeback. It drives register/PC/IR write enables and the memory request handshake, detects illegal encodings and memory timeouts, and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, default 255: maximum wait cycles for `mem_ready` per request; 0 disables the timeout.
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `halt`  in  1  request to stop at the next instruction boundary.
- `r, i, i_load, i_jalr, s, sb, u_auipc, u_lui, uj_jal`  in  1 each  decoder class flags, valid from DECODE onward (IR-driven, stable).
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_addr_sel`  out  1  0 = PC (instruction), 1 = ALU result (data).
- `mem_we`  out  1  data write (stores only).
- `ir_write`  out  1  latch fetched instruction.
- `reg_write`  out  1  register-file write strobe.
- `pc_write`  out  1  PC update strobe; marks retirement.
- `state`  out  3  current FSM state (debug).
- `trap`  out  1  sticky trap flag.
- `trap_cause`  out  2  0 none, 1 illegal, 2 mem timeout.
- `instret`  out  `INSTRET_W`  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- IDLE: all strobes 0; go to FETCH when `halt` = 0.
- FETCH: `mem_req` = 1, `mem_addr_sel` = 0. On `mem_ready`, pulse `ir_write`, go to DECODE.
- DECODE: one cycle.
  - If the count of set flags is not exactly 1, go to TRAP, cause 1.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - `i_load` / `s`: go to MEM.
  - `sb`: pulse `pc_write` (next-PC selection is external), go to boundary.
  - All other classes: go to WRITEBACK.
- MEM: `mem_req` = 1, `mem_addr_sel` = 1, `mem_we` = `s`. On `mem_ready`:
  - store: pulse `pc_write`, go to boundary.
  - load: go to WRITEBACK.
- WRITEBACK: pulse `reg_write` and `pc_write`, go to boundary.
- Boundary: next state is IDLE if `halt` = 1, else FETCH.
- TRAP: all strobes 0. Sticky until `reset`; `trap` = 1, `trap_cause` held.
- Handshake: `mem_req` is a Moore output, held high from entry to FETCH/MEM until the `mem_ready` cycle inclusive. `mem_ready` outside FETCH/MEM is ignored. `mem_addr_sel` and `mem_we` are stable while `mem_req` = 1.
- Timeout (`MEM_TIMEOUT` = N > 0): a wait counter resets on entry to FETCH/MEM and increments on each cycle with `mem_req` = 1 and `mem_ready` = 0.
  - Reaching N goes to TRAP, cause 2; `mem_req` drops the next cycle.
  - `mem_ready` arriving in the same cycle the count reaches N wins: normal completion.
- `instret` increments by 1 on every `pc_write` pulse and wraps modulo 2^`INSTRET_W`.
- `halt` is never honoured mid-instruction.

## Timing
- Reset: state IDLE; all outputs 0; `instret` 0; `trap_cause` 0; wait counter 0.
- Latencies with zero-wait memory (`mem_ready` high in the first request cycle), measured from FETCH entry to `pc_write`:
  - branch: 3 cycles.
  - R/I/U/jal/jalr: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
- Each memory wait cycle adds 1.
- `pc_write`, `reg_write` and `ir_write` are single-cycle pulses, registered-state decoded with no combinational path from `mem_ready`, except `ir_write` and the MEM-state `pc_write`, which are qualified by `mem_ready` in the same cycle.
- `reset` asserted mid-instruction: state and outputs return to reset values at the next edge. No partial writes follow.

## Structure
- Shared package `riscv_ctrl_pkg`: `seq_state_t` enum (3-bit encoding, IDLE = 0) and `trap_cause_t` enum.
- Sub-module `mem_wait_timer` holds the wait counter, its clear/enable logic and the timeout compare against `MEM_TIMEOUT`. It is instantiated once, with the enable tied to `mem_req & ~mem_ready`.

## Test plan
- Reset, then `halt` = 0, R-type flag, `mem_ready` tied 1: states FETCH→DECODE→EXECUTE→WRITEBACK→FETCH. `reg_write` and `pc_write` pulse in cycle 4; `instret` = 1.
- Load with `mem_ready` low 3 cycles in MEM: `mem_req` = 1 and `mem_addr_sel` = 1 held for 4 cycles, then WRITEBACK. `pc_write` at cycle 8; `mem_we` = 0 throughout.
- Store then branch back-to-back, zero-wait: `mem_we` = 1 only in the MEM cycle. `reg_write` never asserts; `instret` = 2 after 7 cycles.
- Flags `r` = 1 and `s` = 1 simultaneously: DECODE→TRAP. `trap` = 1, `trap_cause` = 1, `mem_req` = 0 until `reset`.
- `MEM_TIMEOUT` = 4, `mem_ready` never asserted in FETCH: TRAP, cause 2, after 4 wait cycles. A second run with `mem_ready` in exactly the 4th cycle completes normally.
- `halt` raised during EXECUTE of an I-type: the instruction retires (`instret` +1), then IDLE. Deasserting `halt` resumes FETCH the next cycle. Separately, asserting `reset` mid-MEM clears all outputs within one cycle.
